uvmt_cv32e40s_sl_circ_fifo: RTL and testbench
=============================================

Name: uvmt_cv32e40s_sl_circ_fifo

Overview:
Parametrised circular-buffer FIFO for the cv32e40s support logic. It tracks in-flight items such as OBI requests or transaction tags between the address and response phases, so assertions can match each response to its originating request. It succeeds the shift-register support FIFO with the following additions: arbitrary depth and item type, explicit occupancy count, full/empty/almost-full flags, flush, sticky overflow/underflow error flags, and an optional fall-through mode.

Parameters:
FIFO_TYPE_T, obi_inst_req_t, item type stored; any packed type.
DEPTH, 2, number of entries; must be >= 1; non-power-of-2 allowed.
FALL_THROUGH, 0, 1 = item_i visible on item_o in the same cycle when FIFO is empty and push_i is set.
AFULL_THRESH, DEPTH-1, almost_full_o asserts when count >= AFULL_THRESH; must satisfy 1 <= AFULL_THRESH <= DEPTH.

Ports:
clk_i  in  1  clock; the only clock of the block.
rst_ni  in  1  reset; synchronous, active-low.
flush_i  in  1  discard all entries.
push_i  in  1  write item_i.
pop_i  in  1  consume the head entry.
item_i  in  $bits(FIFO_TYPE_T)  item to write.
item_o  out  $bits(FIFO_TYPE_T)  oldest entry; '0 when empty (except fall-through).
valid_o  out  1  item_o is meaningful (count != 0, or fall-through active).
empty_o  out  1  count == 0.
full_o  out  1  count == DEPTH.
almost_full_o  out  1  count >= AFULL_THRESH.
count_o  out  $clog2(DEPTH+1)  current occupancy.
overflow_o  out  1  sticky: a push was dropped.
underflow_o  out  1  sticky: a pop on empty was ignored.

Behaviour:
- Interface: one clock (clk_i). Reset rst_ni is synchronous and active-low.
- All state updates on posedge clk_i. With rst_ni=0 at an edge, the following are cleared regardless of other inputs: rptr=0, wptr=0, count=0, overflow=0, underflow=0, storage='0.
- Reset values of outputs: item_o='0, valid_o=0, empty_o=1, full_o=0, almost_full_o=0 (1 only if AFULL_THRESH==0, which is illegal), count_o=0, overflow_o=0, underflow_o=0.
- Pointers rptr and wptr are each $clog2(DEPTH) bits wide, minimum 1. Each increments and wraps from DEPTH-1 to 0 with an explicit compare, not natural overflow.
- Accepted push (acc_push) = push_i && (!full || pop_i).
- Accepted pop (acc_pop) = pop_i && !empty.
- Priority: reset > flush_i > push/pop.
- flush_i: rptr=wptr=0 and count=0. Storage does not need clearing, but item_o must read '0 while empty. Sticky flags are kept; only reset clears them. A push in the same cycle as flush_i is discarded; it is not an overflow.
- acc_push only: mem[wptr]<=item_i, wptr++, count++.
- acc_pop only: rptr++, count--.
- Push and pop together, non-empty: both pointers advance and count is unchanged. This is legal when full.
- Push and pop together, empty, FALL_THROUGH=1: item_i is passed to item_o combinationally, valid_o=1, nothing is stored, count stays 0, and no underflow is flagged.
- Push and pop together, empty, FALL_THROUGH=0: the push is stored and the pop is ignored. Set underflow.
- push_i && full && !pop_i: the item is dropped, state is unchanged, and overflow is set on the next cycle.
- pop_i && empty with no fall-through: ignored; underflow is set on the next cycle.
- Latency with FALL_THROUGH=0: a pushed item is visible on item_o one cycle after the push edge. Head update after a pop: the next entry is visible one cycle after the edge.
- item_o = count!=0 ? mem[rptr] : (FALL_THROUGH && push_i ? item_i : '0).
- Flags are combinational from count.
- Elaboration-time $error if DEPTH<1 or AFULL_THRESH is outside [1, DEPTH].

Decomposition:
- Add to uvmt_cv32e40s_support_logic package: function sl_ptr_width(depth) returning max(1, $clog2(depth)).
- No other typedefs are needed. FIFO_TYPE_T is supplied by the instantiator, e.g. obi_inst_req_t or obi_data_req_t.
- One natural sub-module: uvmt_cv32e40s_sl_wrap_ptr (parameter DEPTH; inputs clk_i, rst_ni, clr, inc; output ptr). It holds the wrap-at-DEPTH-1 counter and is instantiated twice.

Test Plan:
- DEPTH=3: push A,B,C over 3 cycles, then push D without pop. Required: full_o=1 and count_o=3 after C; D is dropped; overflow_o=1 the next cycle; item_o=A.
- DEPTH=3, FIFO holding A,B,C: push D with pop for 1 cycle, then pop 3 times. Required: count_o stays 3 after the push/pop cycle; item_o sequence is B,C,D; then empty_o=1 and item_o='0.
- DEPTH=3, empty, FALL_THROUGH=1: push X with pop in one cycle. Required: item_o=X and valid_o=1 in that cycle; count_o=0 and underflow_o=0 afterwards. Same stimulus with FALL_THROUGH=0: count_o=1, item_o=X the next cycle, underflow_o=1.
- DEPTH=5 (non-power-of-2): 12 push/pop pairs with sequential values. Required: FIFO order is preserved across two pointer wraps, and count_o never exceeds 5.
- DEPTH=4, AFULL_THRESH=3, holding 3 entries with overflow_o=1: assert flush_i together with push_i. Required: count_o=0, empty_o=1, almost_full_o=0, overflow_o still 1. Then rst_ni=0 for 1 edge. Required: overflow_o=0 and all outputs at their reset values.

Source files
------------

// File: rtl/uvmt_cv32e40s_sl_circ_fifo_pkg.sv
// Support-logic package for the cv32e40s circular FIFO.
//
// Contents:
//   obi_inst_req_t - default item type for the FIFO (instruction-side OBI
//                    request fields that the support logic tracks).
//   sl_ptr_width() - width of a read/write pointer for a given depth;
//                    never narrower than one bit so DEPTH=1 still has a
//                    legal pointer vector.
package uvmt_cv32e40s_sl_circ_fifo_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
  } obi_inst_req_t;

  // max(1, $clog2(depth))
  function automatic int sl_ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uvmt_cv32e40s_sl_wrap_ptr.sv
// Wrap-at-DEPTH-1 pointer for the circular FIFO.
//
// Ports:
//   clk_i  - clock
//   rst_ni - synchronous active-low reset, clears the pointer
//   clr    - synchronous clear (flush); wins over inc
//   inc    - advance the pointer by one, wrapping DEPTH-1 -> 0
//   ptr    - current pointer value
//
// The wrap uses an explicit compare so non-power-of-2 depths never index
// past the last storage entry.
module uvmt_cv32e40s_sl_wrap_ptr
  import uvmt_cv32e40s_sl_circ_fifo_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = sl_ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/uvmt_cv32e40s_sl_circ_fifo.sv
// Parametrised circular-buffer FIFO used by the cv32e40s support logic to
// keep in-flight items (OBI requests, transaction tags) between the address
// and response phases.
//
// Ports:
//   clk_i         - clock
//   rst_ni        - synchronous active-low reset (pointers, count, sticky
//                   flags and storage)
//   flush_i       - discard all entries; sticky flags are kept
//   push_i        - write item_i
//   pop_i         - consume the head entry
//   item_i        - item to write
//   item_o        - head entry; '0 when empty unless falling through
//   valid_o       - item_o is meaningful
//   empty_o       - count == 0
//   full_o        - count == DEPTH
//   almost_full_o - count >= AFULL_THRESH
//   count_o       - current occupancy
//   overflow_o    - sticky: a push was dropped because the FIFO was full
//   underflow_o   - sticky: a pop on an empty FIFO was ignored
//
// Handshake: push_i/pop_i are level requests evaluated every cycle. A push
// is accepted when not full, or when full together with a pop (the freed
// slot is reused in the same edge). A pop is accepted when not empty. With
// FALL_THROUGH=1 a push+pop on an empty FIFO bypasses storage entirely.
module uvmt_cv32e40s_sl_circ_fifo
  import uvmt_cv32e40s_sl_circ_fifo_pkg::*;
#(
  parameter type FIFO_TYPE_T  = obi_inst_req_t,
  parameter int  DEPTH        = 2,
  parameter bit  FALL_THROUGH = 1'b0,
  parameter int  AFULL_THRESH = DEPTH - 1,
  localparam int PTR_W        = sl_ptr_width(DEPTH),
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  FIFO_TYPE_T       item_i,
  output FIFO_TYPE_T       item_o,
  output logic             valid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("uvmt_cv32e40s_sl_circ_fifo: DEPTH must be >= 1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("uvmt_cv32e40s_sl_circ_fifo: AFULL_THRESH must lie in [1, DEPTH]");
  end

  FIFO_TYPE_T       mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count;
  logic             overflow_q;
  logic             underflow_q;

  logic             empty;
  logic             full;
  logic             bypass;
  logic             acc_push;
  logic             acc_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

  // Fall-through push+pop on an empty FIFO: the item goes straight from
  // item_i to item_o and nothing is stored or counted.
  assign bypass   = FALL_THROUGH && empty && push_i && pop_i;

  assign acc_push = push_i && (!full || pop_i) && !bypass;
  assign acc_pop  = pop_i && !empty;

  uvmt_cv32e40s_sl_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (flush_i),
    .inc    (acc_push),
    .ptr    (wptr)
  );

  uvmt_cv32e40s_sl_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (flush_i),
    .inc    (acc_pop),
    .ptr    (rptr)
  );

  // Storage is only cleared by reset; after a flush stale entries remain
  // but are masked on item_o because count is zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!flush_i && acc_push) begin
      mem[wptr] <= item_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      count <= '0;
    end else begin
      case ({acc_push, acc_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: only reset clears them, and a flush cycle never
  // raises them (its push/pop requests are simply discarded).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (!flush_i) begin
      if (push_i && full && !pop_i) begin
        overflow_q <= 1'b1;
      end
      if (pop_i && empty && !bypass) begin
        underflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    item_o = '0;
    if (!empty) begin
      item_o = mem[rptr];
    end else if (FALL_THROUGH && push_i) begin
      item_o = item_i;
    end
  end

  assign valid_o       = !empty || (FALL_THROUGH && push_i);
  assign empty_o       = empty;
  assign full_o        = full;
  assign almost_full_o = (count >= CNT_W'(AFULL_THRESH));
  assign count_o       = count;
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_uvmt_cv32e40s_sl_circ_fifo.sv
// Bench for uvmt_cv32e40s_sl_circ_fifo. Four instances run side by side:
//   0: DEPTH=3, FALL_THROUGH=1
//   1: DEPTH=3, FALL_THROUGH=0
//   2: DEPTH=5, FALL_THROUGH=0
//   3: DEPTH=4, FALL_THROUGH=0, AFULL_THRESH=3
// Each instance has its own inputs and a queue-based reference model; every
// cycle all outputs of all instances are compared with the model, and the
// directed steps add explicit constant expectations on top.
module tb_uvmt_cv32e40s_sl_circ_fifo;

  localparam int N = 4;
  localparam int DEP [N] = '{3, 3, 5, 4};
  localparam int FT  [N] = '{1, 0, 0, 0};
  localparam int AF  [N] = '{2, 2, 4, 3};

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [N];
  logic       flush [N];
  logic       push  [N];
  logic       pop   [N];
  logic [7:0] din   [N];

  wire  [7:0] item_w  [N];
  wire        valid_w [N];
  wire        empty_w [N];
  wire        full_w  [N];
  wire        afull_w [N];
  wire        ovf_w   [N];
  wire        unf_w   [N];
  wire  [2:0] cnt_w   [N];
  wire  [1:0] c0;
  wire  [1:0] c1;
  wire  [2:0] c2;
  wire  [2:0] c3;

  assign cnt_w[0] = {1'b0, c0};
  assign cnt_w[1] = {1'b0, c1};
  assign cnt_w[2] = c2;
  assign cnt_w[3] = c3;

  uvmt_cv32e40s_sl_circ_fifo #(.FIFO_TYPE_T(logic [7:0]), .DEPTH(3), .FALL_THROUGH(1'b1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .flush_i(flush[0]), .push_i(push[0]), .pop_i(pop[0]),
    .item_i(din[0]), .item_o(item_w[0]), .valid_o(valid_w[0]), .empty_o(empty_w[0]),
    .full_o(full_w[0]), .almost_full_o(afull_w[0]), .count_o(c0),
    .overflow_o(ovf_w[0]), .underflow_o(unf_w[0]));

  uvmt_cv32e40s_sl_circ_fifo #(.FIFO_TYPE_T(logic [7:0]), .DEPTH(3), .FALL_THROUGH(1'b0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .flush_i(flush[1]), .push_i(push[1]), .pop_i(pop[1]),
    .item_i(din[1]), .item_o(item_w[1]), .valid_o(valid_w[1]), .empty_o(empty_w[1]),
    .full_o(full_w[1]), .almost_full_o(afull_w[1]), .count_o(c1),
    .overflow_o(ovf_w[1]), .underflow_o(unf_w[1]));

  uvmt_cv32e40s_sl_circ_fifo #(.FIFO_TYPE_T(logic [7:0]), .DEPTH(5), .FALL_THROUGH(1'b0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .flush_i(flush[2]), .push_i(push[2]), .pop_i(pop[2]),
    .item_i(din[2]), .item_o(item_w[2]), .valid_o(valid_w[2]), .empty_o(empty_w[2]),
    .full_o(full_w[2]), .almost_full_o(afull_w[2]), .count_o(c2),
    .overflow_o(ovf_w[2]), .underflow_o(unf_w[2]));

  uvmt_cv32e40s_sl_circ_fifo #(.FIFO_TYPE_T(logic [7:0]), .DEPTH(4), .FALL_THROUGH(1'b0),
                               .AFULL_THRESH(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n[3]), .flush_i(flush[3]), .push_i(push[3]), .pop_i(pop[3]),
    .item_i(din[3]), .item_o(item_w[3]), .valid_o(valid_w[3]), .empty_o(empty_w[3]),
    .full_o(full_w[3]), .almost_full_o(afull_w[3]), .count_o(c3),
    .overflow_o(ovf_w[3]), .underflow_o(unf_w[3]));

  // scoreboard / reference model
  logic [7:0] exp_q [N][$];
  logic       exp_ovf [N];
  logic       exp_unf [N];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input int i, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  // Compare every output of every instance with what the model predicts
  // for the current state and the inputs currently applied.
  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      int         cnt;
      logic [7:0] e_item;
      logic       e_valid;
      cnt = exp_q[i].size();
      if (cnt != 0)                  e_item = exp_q[i][0];
      else if (FT[i] == 1 && push[i]) e_item = din[i];
      else                           e_item = 8'h00;
      e_valid = (cnt != 0) || (FT[i] == 1 && push[i]);
      check("item_o",        i, 32'(item_w[i]),  32'(e_item));
      check("valid_o",       i, 32'(valid_w[i]), 32'(e_valid));
      check("empty_o",       i, 32'(empty_w[i]), 32'(cnt == 0));
      check("full_o",        i, 32'(full_w[i]),  32'(cnt == DEP[i]));
      check("almost_full_o", i, 32'(afull_w[i]), 32'(cnt >= AF[i]));
      check("count_o",       i, 32'(cnt_w[i]),   32'(cnt));
      check("overflow_o",    i, 32'(ovf_w[i]),   32'(exp_ovf[i]));
      check("underflow_o",   i, 32'(unf_w[i]),   32'(exp_unf[i]));
    end
  endtask

  // Advance the model of instance i by one clock edge with its current inputs.
  task automatic model_step(input int i);
    int cnt;
    bit is_full;
    bit is_empty;
    bit byp;
    cnt      = exp_q[i].size();
    is_full  = (cnt == DEP[i]);
    is_empty = (cnt == 0);
    byp      = (FT[i] == 1) && is_empty && push[i] && pop[i];
    if (!rst_n[i]) begin
      exp_q[i].delete();
      exp_ovf[i] = 1'b0;
      exp_unf[i] = 1'b0;
    end else if (flush[i]) begin
      exp_q[i].delete();
    end else begin
      if (push[i] && is_full && !pop[i]) exp_ovf[i] = 1'b1;
      if (pop[i] && is_empty && !byp)    exp_unf[i] = 1'b1;
      if (pop[i] && !is_empty)           void'(exp_q[i].pop_front());
      if (push[i] && !byp && (!is_full || pop[i])) exp_q[i].push_back(din[i]);
    end
  endtask

  // driver tasks
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b1;
      flush[i] = 1'b0;
      push[i]  = 1'b0;
      pop[i]   = 1'b0;
      din[i]   = 8'h00;
    end
  endtask

  initial begin
    idle_all();
    for (int i = 0; i < N; i++) begin
      rst_n[i]   = 1'b0;
      exp_ovf[i] = 1'b0;
      exp_unf[i] = 1'b0;
    end
    // First edge brings the DUTs out of X; compare from then on.
    @(posedge clk);
    #1;
    tick();
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    // reset values
    for (int i = 0; i < N; i++) begin
      check("rst_empty", i, 32'(empty_w[i]), 32'd1);
      check("rst_count", i, 32'(cnt_w[i]),   32'd0);
      check("rst_item",  i, 32'(item_w[i]),  32'd0);
    end

    // DEPTH=3: fill with A,B,C then push D while full
    push[1] = 1'b1; din[1] = 8'hA1; tick();
    din[1] = 8'hB2; tick();
    din[1] = 8'hC3; tick();
    check("full_after_c",  1, 32'(full_w[1]), 32'd1);
    check("count_after_c", 1, 32'(cnt_w[1]),  32'd3);
    din[1] = 8'hD4; tick();
    push[1] = 1'b0;
    check("ovf_after_d",  1, 32'(ovf_w[1]),  32'd1);
    check("item_after_d", 1, 32'(item_w[1]), 32'hA1);
    check("cnt_after_d",  1, 32'(cnt_w[1]),  32'd3);

    // push D with pop while full, then drain
    push[1] = 1'b1; pop[1] = 1'b1; din[1] = 8'hD4; tick();
    push[1] = 1'b0;
    check("cnt_pushpop", 1, 32'(cnt_w[1]),  32'd3);
    check("head_b",      1, 32'(item_w[1]), 32'hB2);
    tick();
    check("head_c", 1, 32'(item_w[1]), 32'hC3);
    tick();
    check("head_d", 1, 32'(item_w[1]), 32'hD4);
    tick();
    pop[1] = 1'b0;
    check("drained_empty", 1, 32'(empty_w[1]), 32'd1);
    check("drained_item",  1, 32'(item_w[1]),  32'd0);

    // push+pop on empty: fall-through (inst 0) vs stored (inst 1)
    for (int i = 0; i < 2; i++) begin
      push[i] = 1'b1; pop[i] = 1'b1; din[i] = 8'h5A;
    end
    #1;
    check("ft_item",  0, 32'(item_w[0]),  32'h5A);
    check("ft_valid", 0, 32'(valid_w[0]), 32'd1);
    tick();
    idle_all();
    check("ft_count", 0, 32'(cnt_w[0]),  32'd0);
    check("ft_unf",   0, 32'(unf_w[0]),  32'd0);
    check("nft_count", 1, 32'(cnt_w[1]), 32'd1);
    check("nft_item",  1, 32'(item_w[1]), 32'h5A);
    check("nft_unf",   1, 32'(unf_w[1]), 32'd1);

    // DEPTH=5: prefill 0..3, then 12 push/pop pairs with values 4..15
    push[2] = 1'b1;
    for (int v = 0; v < 4; v++) begin
      din[2] = 8'(v); tick();
    end
    pop[2] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      din[2] = 8'(j + 3); tick();
      check("wrap_head", 2, 32'(item_w[2]), 32'(j));
      check("wrap_cnt_le5", 2, 32'(cnt_w[2] <= 3'd5), 32'd1);
    end
    push[2] = 1'b0;
    for (int j = 13; j <= 16; j++) begin
      tick();
      if (j < 16) check("drain_head", 2, 32'(item_w[2]), 32'(j));
    end
    pop[2] = 1'b0;
    check("wrap_empty", 2, 32'(empty_w[2]), 32'd1);

    // DEPTH=4, AFULL_THRESH=3: overflow, back to 3 entries, flush, reset
    push[3] = 1'b1;
    for (int v = 0; v < 5; v++) begin
      din[3] = 8'(8'h10 + v); tick();
    end
    push[3] = 1'b0; pop[3] = 1'b1; tick();
    pop[3] = 1'b0;
    check("pre_flush_cnt",   3, 32'(cnt_w[3]),   32'd3);
    check("pre_flush_afull", 3, 32'(afull_w[3]), 32'd1);
    check("pre_flush_ovf",   3, 32'(ovf_w[3]),   32'd1);
    flush[3] = 1'b1; push[3] = 1'b1; din[3] = 8'h99; tick();
    flush[3] = 1'b0; push[3] = 1'b0;
    check("flush_cnt",   3, 32'(cnt_w[3]),   32'd0);
    check("flush_empty", 3, 32'(empty_w[3]), 32'd1);
    check("flush_afull", 3, 32'(afull_w[3]), 32'd0);
    check("flush_ovf",   3, 32'(ovf_w[3]),   32'd1);
    check("flush_item",  3, 32'(item_w[3]),  32'd0);
    rst_n[3] = 1'b0; tick();
    rst_n[3] = 1'b1;
    check("rst2_ovf",   3, 32'(ovf_w[3]),   32'd0);
    check("rst2_unf",   3, 32'(unf_w[3]),   32'd0);
    check("rst2_cnt",   3, 32'(cnt_w[3]),   32'd0);
    check("rst2_empty", 3, 32'(empty_w[3]), 32'd1);
    check("rst2_full",  3, 32'(full_w[3]),  32'd0);
    check("rst2_afull", 3, 32'(afull_w[3]), 32'd0);
    check("rst2_valid", 3, 32'(valid_w[3]), 32'd0);
    check("rst2_item",  3, 32'(item_w[3]),  32'd0);

    // randomized traffic on all instances against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        push[i]  = ($urandom_range(0, 99) < 55);
        pop[i]   = ($urandom_range(0, 99) < 50);
        flush[i] = ($urandom_range(0, 99) < 3);
        rst_n[i] = !($urandom_range(0, 199) < 1);
        din[i]   = 8'($urandom_range(0, 255));
      end
      tick();
    end
    idle_all();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
